// File: rtl/hicore_icb_arbt_if.sv
`default_nettype none
// ============================================================================
// Module   : hicore_icb_arbt_if
// Purpose  : Bundle of the two-initiator ICB ports and the single target ICB
//            port seen by the ICB arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface hicore_icb_arbt_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Initiator side (two initiators, bit/slice n = initiator n)
  logic [1:0]          i_bus_icb_cmd_valid;
  logic [1:0]          i_bus_icb_cmd_ready;
  logic [1:0]          i_bus_icb_cmd_read;
  logic [2*AW-1:0]     i_bus_icb_cmd_addr;
  logic [2*DW-1:0]     i_bus_icb_cmd_wdata;
  logic [2*DW/8-1:0]   i_bus_icb_cmd_wmask;
  logic [1:0]          i_bus_icb_rsp_valid;
  logic [1:0]          i_bus_icb_rsp_ready;
  logic [1:0]          i_bus_icb_rsp_err;
  logic [2*DW-1:0]     i_bus_icb_rsp_rdata;

  // Target side
  logic                o_icb_cmd_valid;
  logic                o_icb_cmd_ready;
  logic                o_icb_cmd_read;
  logic [AW-1:0]       o_icb_cmd_addr;
  logic [DW-1:0]       o_icb_cmd_wdata;
  logic [DW/8-1:0]     o_icb_cmd_wmask;
  logic                o_icb_rsp_valid;
  logic                o_icb_rsp_ready;
  logic                o_icb_rsp_err;
  logic [DW-1:0]       o_icb_rsp_rdata;

  // Arbiter view
  modport slave (
    input  i_bus_icb_cmd_valid, i_bus_icb_cmd_read, i_bus_icb_cmd_addr,
           i_bus_icb_cmd_wdata, i_bus_icb_cmd_wmask, i_bus_icb_rsp_ready,
           o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
    output i_bus_icb_cmd_ready, i_bus_icb_rsp_valid, i_bus_icb_rsp_err,
           i_bus_icb_rsp_rdata, o_icb_cmd_valid, o_icb_cmd_read,
           o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
  );

  // Environment view (initiators plus target)
  modport master (
    output i_bus_icb_cmd_valid, i_bus_icb_cmd_read, i_bus_icb_cmd_addr,
           i_bus_icb_cmd_wdata, i_bus_icb_cmd_wmask, i_bus_icb_rsp_ready,
           o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
    input  i_bus_icb_cmd_ready, i_bus_icb_rsp_valid, i_bus_icb_rsp_err,
           i_bus_icb_rsp_rdata, o_icb_cmd_valid, o_icb_cmd_read,
           o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/hicore_icb_arbt.sv
`default_nettype none
// ============================================================================
// Module   : hicore_icb_arbt
// Purpose  : Two-to-one ICB arbiter. Round-robin command arbitration with a
//            grant lock while the target stalls, and an in-order outstanding
//            id FIFO that steers responses back to the issuing initiator.
// Revision : 1.0 - initial release
// ============================================================================
module hicore_icb_arbt #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hicore_icb_arbt_if.slave   bus
);

  // Pointer and occupancy widths; a depth of 1 still needs a 1-bit pointer
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(OUTS_DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(OUTS_DEPTH - 1);

  // Arbitration state
  logic          rr_ptr_q,  rr_ptr_d;
  logic          lock_q,    lock_d;
  logic          lock_id_q, lock_id_d;

  // Outstanding id FIFO
  logic          id_mem_q [OUTS_DEPTH];
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_gnt_id;
  logic w_head_id;
  logic w_cmd_valid;
  logic w_cmd_hs;
  logic w_rsp_ready;
  logic w_rsp_hs;

  assign w_fifo_full  = (cnt_q == C_DEPTH);
  assign w_fifo_empty = (cnt_q == '0);
  assign w_head_id    = id_mem_q[rd_ptr_q];

  // A locked grant sticks to the stalled initiator; otherwise rr_ptr has
  // priority and the other initiator wins only when rr_ptr is idle
  assign w_gnt_id = lock_q ? lock_id_q
                  : (bus.i_bus_icb_cmd_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q);

  // Command path: purely combinational mux from the granted initiator
  assign w_cmd_valid          = (|bus.i_bus_icb_cmd_valid) & ~w_fifo_full;
  assign w_cmd_hs             = w_cmd_valid & bus.o_icb_cmd_ready;
  assign bus.o_icb_cmd_valid  = w_cmd_valid;
  assign bus.o_icb_cmd_read   = bus.i_bus_icb_cmd_read[w_gnt_id];
  assign bus.o_icb_cmd_addr   = w_gnt_id ? bus.i_bus_icb_cmd_addr[2*AW-1:AW]
                                         : bus.i_bus_icb_cmd_addr[AW-1:0];
  assign bus.o_icb_cmd_wdata  = w_gnt_id ? bus.i_bus_icb_cmd_wdata[2*DW-1:DW]
                                         : bus.i_bus_icb_cmd_wdata[DW-1:0];
  assign bus.o_icb_cmd_wmask  = w_gnt_id ? bus.i_bus_icb_cmd_wmask[2*DW/8-1:DW/8]
                                         : bus.i_bus_icb_cmd_wmask[DW/8-1:0];
  assign bus.i_bus_icb_cmd_ready = (bus.o_icb_cmd_ready & ~w_fifo_full)
                                   ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Response path: route to the initiator at the FIFO head; a response with
  // nothing outstanding is neither forwarded nor accepted
  assign w_rsp_ready          = bus.i_bus_icb_rsp_ready[w_head_id] & ~w_fifo_empty;
  assign w_rsp_hs             = bus.o_icb_rsp_valid & w_rsp_ready;
  assign bus.o_icb_rsp_ready  = w_rsp_ready;
  assign bus.i_bus_icb_rsp_valid = (bus.o_icb_rsp_valid & ~w_fifo_empty)
                                   ? (w_head_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.i_bus_icb_rsp_err   = {2{bus.o_icb_rsp_err}};
  assign bus.i_bus_icb_rsp_rdata = {2{bus.o_icb_rsp_rdata}};

  // Next-state for arbitration and FIFO bookkeeping
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    if (w_cmd_hs) begin
      rr_ptr_d = ~w_gnt_id;
      lock_d   = 1'b0;
    end else if (w_cmd_valid) begin
      lock_d    = 1'b1;
      lock_id_d = w_gnt_id;
    end

    if (w_cmd_hs) begin
      wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (w_rsp_hs) begin
      rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    // Push is already gated by full, so push+pop leaves the count unchanged
    case ({w_cmd_hs, w_rsp_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset drops every outstanding id
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage: record the granted id on every accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        id_mem_q[i] <= 1'b0;
      end
    end else if (w_cmd_hs) begin
      id_mem_q[wr_ptr_q] <= w_gnt_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hicore_icb_arbt.sv
`default_nettype none
// ============================================================================
// Module   : tb_hicore_icb_arbt
// Purpose  : Randomised and directed stimulus for hicore_icb_arbt, checked
//            cycle by cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hicore_icb_arbt;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  hicore_icb_arbt_if #(.AW(AW), .DW(DW)) u_bus ();

  hicore_icb_arbt #(.AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue of outstanding initiator ids in issue order,
  // the initiator that has priority next, and the held (stalled) grant
  int q_ids[$];
  int rr;
  bit locked;
  int lock_gnt;

  // Per-cycle expectations shared between check and commit phases
  bit       e_cmd_valid;
  bit       e_hs;
  bit       e_pop;
  int       e_gnt;
  bit [1:0] e_accepted;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the model at the falling edge
  task automatic check_cycle();
    bit [1:0] v;
    bit       full, empty;
    int       head;
    logic [1:0] e_rdy, e_rvld;
    logic     e_rrdy;
    logic [63:0] tmp;
    @(negedge clk);
    v     = u_bus.i_bus_icb_cmd_valid;
    full  = (q_ids.size() >= DEPTH);
    empty = (q_ids.size() == 0);
    if (locked)            e_gnt = lock_gnt;
    else if (v[rr] == 1'b1) e_gnt = rr;
    else                   e_gnt = 1 - rr;
    e_cmd_valid = (v != 2'b00) && !full;
    e_rdy = (u_bus.o_icb_cmd_ready && !full) ? (2'b01 << e_gnt) : 2'b00;
    chk_val("cmd_valid", u_bus.o_icb_cmd_valid, e_cmd_valid);
    chk_val("cmd_ready", u_bus.i_bus_icb_cmd_ready, e_rdy);
    if (e_cmd_valid) begin
      tmp = u_bus.i_bus_icb_cmd_addr;
      chk_val("cmd_addr", u_bus.o_icb_cmd_addr, tmp[e_gnt*AW +: AW]);
      tmp = u_bus.i_bus_icb_cmd_wdata;
      chk_val("cmd_wdata", u_bus.o_icb_cmd_wdata, tmp[e_gnt*DW +: DW]);
      tmp = u_bus.i_bus_icb_cmd_wmask;
      chk_val("cmd_wmask", u_bus.o_icb_cmd_wmask, tmp[e_gnt*4 +: 4]);
      chk_val("cmd_read", u_bus.o_icb_cmd_read, u_bus.i_bus_icb_cmd_read[e_gnt]);
    end
    head   = empty ? 0 : q_ids[0];
    e_rrdy = !empty && u_bus.i_bus_icb_rsp_ready[head];
    e_rvld = (!empty && u_bus.o_icb_rsp_valid) ? (2'b01 << head) : 2'b00;
    chk_val("rsp_ready", u_bus.o_icb_rsp_ready, e_rrdy);
    chk_val("rsp_valid", u_bus.i_bus_icb_rsp_valid, e_rvld);
    chk_val("rsp_rdata", u_bus.i_bus_icb_rsp_rdata,
            {u_bus.o_icb_rsp_rdata, u_bus.o_icb_rsp_rdata});
    chk_val("rsp_err", u_bus.i_bus_icb_rsp_err,
            {u_bus.o_icb_rsp_err, u_bus.o_icb_rsp_err});
    e_hs       = e_cmd_valid && u_bus.o_icb_cmd_ready;
    e_pop      = u_bus.o_icb_rsp_valid && e_rrdy;
    e_accepted = e_hs ? (2'b01 << e_gnt) : 2'b00;
  endtask

  // Advance the model on the rising edge, then leave 1 time unit for drivers
  task automatic commit_cycle();
    @(posedge clk);
    if (rst) begin
      q_ids.delete();
      rr     = 0;
      locked = 0;
    end else begin
      if (e_pop) void'(q_ids.pop_front());
      if (e_hs) begin
        q_ids.push_back(e_gnt);
        rr     = 1 - e_gnt;
        locked = 0;
      end else if (e_cmd_valid) begin
        locked   = 1;
        lock_gnt = e_gnt;
      end
    end
    #1;
  endtask

  // Initiators hold a command until accepted, then maybe issue a new one
  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (!u_bus.i_bus_icb_cmd_valid[n] || e_accepted[n]) begin
        u_bus.i_bus_icb_cmd_valid[n]          = ($urandom_range(0, 99) < 60);
        u_bus.i_bus_icb_cmd_read[n]           = $urandom_range(0, 1) == 1;
        u_bus.i_bus_icb_cmd_addr[n*AW +: AW]  = $urandom;
        u_bus.i_bus_icb_cmd_wdata[n*DW +: DW] = $urandom;
        u_bus.i_bus_icb_cmd_wmask[n*4 +: 4]   = 4'($urandom_range(0, 15));
      end
    end
    u_bus.o_icb_cmd_ready     = ($urandom_range(0, 3) != 0);
    u_bus.o_icb_rsp_valid     = ($urandom_range(0, 2) != 0);
    u_bus.o_icb_rsp_err       = ($urandom_range(0, 7) == 0);
    u_bus.o_icb_rsp_rdata     = $urandom;
    u_bus.i_bus_icb_rsp_ready = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
    rst = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    rst = 1'b1;
    u_bus.i_bus_icb_cmd_valid = '0;
    u_bus.i_bus_icb_cmd_read  = '0;
    u_bus.i_bus_icb_cmd_addr  = '0;
    u_bus.i_bus_icb_cmd_wdata = '0;
    u_bus.i_bus_icb_cmd_wmask = '0;
    u_bus.i_bus_icb_rsp_ready = '0;
    u_bus.o_icb_cmd_ready     = 1'b0;
    u_bus.o_icb_rsp_valid     = 1'b0;
    u_bus.o_icb_rsp_err       = 1'b0;
    u_bus.o_icb_rsp_rdata     = '0;
    rr = 0; locked = 0; lock_gnt = 0;
    e_accepted = '0; e_hs = 0; e_pop = 0; e_cmd_valid = 0; e_gnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with target ready and a stray response present
    u_bus.o_icb_cmd_ready = 1'b1;
    u_bus.o_icb_rsp_valid = 1'b1;
    check_cycle();
    chk_val("rst_rsp_valid", u_bus.i_bus_icb_rsp_valid, 2'b00);
    chk_val("rst_rsp_ready", u_bus.o_icb_rsp_ready, 1'b0);
    commit_cycle();
    rst = 1'b0;

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      drive_random();
      check_cycle();
      commit_cycle();
    end

    // Directed: fill, full blocking, in-order routed responses, reset flush
    rst = 1'b1;
    u_bus.o_icb_rsp_valid = 1'b0;
    check_cycle();
    commit_cycle();
    rst = 1'b0;
    u_bus.i_bus_icb_cmd_valid = 2'b11;
    u_bus.i_bus_icb_cmd_addr  = {32'hB000_0001, 32'hA000_0000};
    u_bus.o_icb_cmd_ready     = 1'b1;
    u_bus.i_bus_icb_rsp_ready = 2'b11;
    u_bus.o_icb_rsp_err       = 1'b0;
    check_cycle();
    chk_val("d_gnt0", u_bus.i_bus_icb_cmd_ready, 2'b01);
    chk_val("d_addr0", u_bus.o_icb_cmd_addr, 32'hA000_0000);
    commit_cycle();
    check_cycle();
    chk_val("d_gnt1", u_bus.i_bus_icb_cmd_ready, 2'b10);
    chk_val("d_addr1", u_bus.o_icb_cmd_addr, 32'hB000_0001);
    commit_cycle();
    check_cycle();
    chk_val("d_full_vld", u_bus.o_icb_cmd_valid, 1'b0);
    chk_val("d_full_rdy", u_bus.i_bus_icb_cmd_ready, 2'b00);
    commit_cycle();
    u_bus.o_icb_rsp_valid = 1'b1;
    u_bus.o_icb_rsp_rdata = 32'hA5A5_A5A5;
    check_cycle();
    chk_val("d_rsp0_vld", u_bus.i_bus_icb_rsp_valid, 2'b01);
    chk_val("d_rsp0_data", u_bus.i_bus_icb_rsp_rdata[31:0], 32'hA5A5_A5A5);
    chk_val("d_pop_blk", u_bus.o_icb_cmd_valid, 1'b0);
    commit_cycle();
    u_bus.o_icb_rsp_valid = 1'b0;
    check_cycle();
    chk_val("d_refill", u_bus.i_bus_icb_cmd_ready, 2'b01);
    commit_cycle();
    u_bus.o_icb_rsp_valid = 1'b1;
    u_bus.o_icb_rsp_rdata = 32'h5A5A_5A5A;
    check_cycle();
    chk_val("d_rsp1_vld", u_bus.i_bus_icb_rsp_valid, 2'b10);
    chk_val("d_rsp1_data", u_bus.i_bus_icb_rsp_rdata[63:32], 32'h5A5A_5A5A);
    commit_cycle();
    u_bus.o_icb_rsp_valid = 1'b0;
    check_cycle();
    commit_cycle();
    rst = 1'b1;
    check_cycle();
    commit_cycle();
    rst = 1'b0;
    u_bus.o_icb_rsp_valid = 1'b1;
    check_cycle();
    chk_val("d_rst_rvld", u_bus.i_bus_icb_rsp_valid, 2'b00);
    chk_val("d_rst_rrdy", u_bus.o_icb_rsp_ready, 1'b0);
    chk_val("d_rst_gnt", u_bus.i_bus_icb_cmd_ready, 2'b01);
    commit_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
